// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared digit types and the leading-zero blanking rule for the display blocks.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] nibble_t;
    typedef logic [NUM_DIGITS-1:0] digit_mask_t;

    // Digit i is a leading zero when it and every more-significant nibble are zero; digit 0 always shows.
    function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] value, input logic [2:0] i);
        return (i != 3'd0) && ((value >> {i, 2'b00}) == '0);
    endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// seven_seg_prescaler: divides clk down to a one-cycle tick every REFRESH_DIV cycles.
module seven_seg_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == W'(REFRESH_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-buffered 8-digit hex scanner feeding a 7-segment decoder one digit per slot.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [3:0]  q,
    output logic [7:0]  an_in,
    output logic        dp_sw,
    output logic        pending,
    output logic        frame
);

    logic        tick;
    logic        swap;
    logic        dark;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] pend_value_q, pend_value_d, disp_value_q, disp_value_d;
    digit_mask_t pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    digit_mask_t pend_en_q, pend_en_d, disp_en_q, disp_en_d;
    logic        pend_blz_q, pend_blz_d, disp_blz_q, disp_blz_d;
    logic        pending_q, pending_d;
    nibble_t     q_q, q_d;
    digit_mask_t an_q, an_d;
    logic        dp_q, dp_d;
    logic        frame_q, frame_d;

    seven_seg_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        swap         = tick && (idx_q == 3'd7) && pending_q;
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        pending_d    = load || (pending_q && !swap);
        pend_value_d = load ? value    : pend_value_q;
        pend_dp_d    = load ? dp_mask  : pend_dp_q;
        pend_en_d    = load ? digit_en : pend_en_q;
        pend_blz_d   = load ? blank_lz : pend_blz_q;
        disp_value_d = swap ? pend_value_q : disp_value_q;
        disp_dp_d    = swap ? pend_dp_q    : disp_dp_q;
        disp_en_d    = swap ? pend_en_q    : disp_en_q;
        disp_blz_d   = swap ? pend_blz_q   : disp_blz_q;
        // Render from the post-swap display set so digit 0 of a new frame already uses new data.
        dark         = !disp_en_d[idx_d] || (disp_blz_d && lz_blank(disp_value_d, idx_d));
        q_d          = tick ? disp_value_d[{idx_d, 2'b00} +: 4] : q_q;
        an_d         = tick ? (dark ? '0 : digit_mask_t'(1) << idx_d) : an_q;
        dp_d         = tick ? (!dark && disp_dp_d[idx_d]) : dp_q;
        frame_d      = tick && (idx_q == 3'd7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= 3'd7;
            pending_q    <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_blz_q   <= 1'b0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            disp_blz_q   <= 1'b0;
            q_q          <= '0;
            an_q         <= '0;
            dp_q         <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_blz_q   <= pend_blz_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            disp_blz_q   <= disp_blz_d;
            q_q          <= q_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign q       = q_q;
    assign an_in   = an_q;
    assign dp_sw   = dp_q;
    assign pending = pending_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan with REFRESH_DIV=4.
module tb_seven_seg_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  digit_en = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  q;
    logic [7:0]  an_in;
    logic        dp_sw;
    logic        pending;
    logic        frame;

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] q;
        logic       dp;
    } slot_t;

    slot_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .dp_mask  (dp_mask),
        .digit_en (digit_en),
        .blank_lz (blank_lz),
        .q        (q),
        .an_in    (an_in),
        .dp_sw    (dp_sw),
        .pending  (pending),
        .frame    (frame)
    );

    task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en, input logic blz);
        value    = v;
        dp_mask  = dp;
        digit_en = en;
        blank_lz = blz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Expected slot contents for one whole frame, derived from the loaded settings.
    task automatic push_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en, input logic blz);
        for (int n = 0; n < 8; n++) begin
            logic [31:0] rest;
            logic        lit;
            slot_t       s;
            rest  = v >> (4 * n);
            lit   = en[n] && !(blz && n != 0 && rest == 32'd0);
            s.an  = lit ? 8'(1 << n) : 8'h00;
            s.q   = rest[3:0];
            s.dp  = lit && dp[n];
            sb.push_back(s);
        end
    endtask

    task automatic wait_frame(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!frame && i < 100);
        checks++;
        if (frame !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame pulse not seen within 100 cycles", name);
        end
    endtask

    task automatic check_frame(input string name);
        for (int s = 0; s < 8; s++) begin
            slot_t e;
            if (s != 0) repeat (DIV) @(negedge clk);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s slot %0d: scoreboard empty", name, s);
            end else begin
                e = sb.pop_front();
                if ({an_in, q, dp_sw} !== e) begin
                    errors++;
                    $display("FAIL %s slot %0d: an_in=%h q=%h dp_sw=%b, expected an_in=%h q=%h dp_sw=%b",
                             name, s, an_in, q, dp_sw, e.an, e.q, e.dp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({an_in, q, dp_sw, pending, frame} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: an_in=%h q=%h dp_sw=%b pending=%b frame=%b, expected all zero",
                     an_in, q, dp_sw, pending, frame);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            logic exp_frame;
            @(negedge clk);
            exp_frame = (c == 3 || c == 35);
            checks++;
            if ({an_in, q, pending, frame} !== {8'h00, 4'h0, 1'b0, exp_frame}) begin
                errors++;
                $display("FAIL idle cycle %0d: an_in=%h q=%h pending=%b frame=%b, expected an_in=00 q=0 pending=0 frame=%b",
                         c, an_in, q, pending, frame, exp_frame);
            end
        end
    endtask

    task automatic test_display(input string name, input logic [31:0] v, input logic [7:0] dp,
                                input logic [7:0] en, input logic blz);
        wait_frame({name, " sync"});
        do_load(v, dp, en, blz);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL %s pending_set: pending=%b, expected 1", name, pending);
        end
        push_frame(v, dp, en, blz);
        wait_frame({name, " swap"});
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL %s pending_clear: pending=%b, expected 0", name, pending);
        end
        check_frame(name);
    endtask

    task automatic test_basic();
        test_display("basic", 32'h12345678, 8'h04, 8'hFF, 1'b0);
    endtask

    task automatic test_blank_lz();
        test_display("blank_lz", 32'h000000A0, 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_digit_en();
        test_display("digit_en", 32'hFFFFFFFF, 8'h00, 8'h0F, 1'b0);
    endtask

    task automatic test_back_to_back();
        wait_frame("b2b sync");
        do_load(32'h11111111, 8'h00, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        do_load(32'h22222222, 8'h00, 8'hFF, 1'b0);
        repeat (26) @(negedge clk);
        do_load(32'h33333333, 8'h00, 8'hFF, 1'b0);
        checks++;
        if ({frame, pending} !== 2'b11) begin
            errors++;
            $display("FAIL b2b swap_with_load: frame=%b pending=%b, expected frame=1 pending=1", frame, pending);
        end
        push_frame(32'h22222222, 8'h00, 8'hFF, 1'b0);
        check_frame("b2b last_wins");
        push_frame(32'h33333333, 8'h00, 8'hFF, 1'b0);
        wait_frame("b2b third");
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL b2b third_pending: pending=%b, expected 0", pending);
        end
        check_frame("b2b third");
    endtask

    task automatic test_async_reset();
        wait_frame("arst sync");
        do_load(32'h12345678, 8'h04, 8'hFF, 1'b0);
        wait_frame("arst swap");
        repeat (5 * DIV) @(negedge clk);
        checks++;
        if (an_in !== 8'h20) begin
            errors++;
            $display("FAIL arst slot5: an_in=%h, expected 20", an_in);
        end
        do_load(32'hABCDEF01, 8'hFF, 8'hFF, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({an_in, q, dp_sw, pending} !== 14'd0) begin
            errors++;
            $display("FAIL arst immediate: an_in=%h q=%h dp_sw=%b pending=%b, expected all zero",
                     an_in, q, dp_sw, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        push_frame(32'h0, 8'h00, 8'h00, 1'b0);
        wait_frame("arst after");
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL arst pending_discard: pending=%b, expected 0", pending);
        end
        check_frame("arst dark");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank_lz();
        test_digit_en();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
